mem_ctrl_p: RTL

Parametrised multi-cycle program controller: the next generation of the lab's 16-bit memory controller. Fetches 16-bit instructions from an internal program memory, decodes them, reads a register file, executes in an ALU and writes back, one instruction per five cycles. Adds a configurable data width and program depth, a host program-load port, HALT, carry/zero flags and a single-step mode. Sits between the lab test fixtures and future datapath blocks.

---
 rtl/mc_pkg.sv | 49 ++++
 rtl/mc_alu.sv | 56 +++++
 rtl/mem_ctrl_p.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the mem_ctrl_p program controller.
//   state_t  - FSM state encoding, also the value exported on curr
//   OP_*     - 4-bit opcodes held in instruction bits [15:12]
//   *_LSB    - instruction field positions, each field FIELD_W bits wide
//   is_flag_op / writes_reg - opcode class helpers shared by datapath and ALU
package mc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_READ   = 4'd3,
    ST_EXEC   = 4'd4,
    ST_WB     = 4'd5,
    ST_PAUSE  = 4'd6,
    ST_DONE   = 4'd7
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int INSTR_W  = 16;
  localparam int FIELD_W  = 4;
  localparam int OPC_LSB  = 12;
  localparam int DST_LSB  = 8;
  localparam int SRC1_LSB = 4;
  localparam int SRC2_LSB = 0;
  localparam int NUM_REGS = 16;

  // Arithmetic, logic and shift ops own the carry/zero flags.
  function automatic logic is_flag_op(input logic [3:0] op);
    return op <= OP_SHR;
  endfunction

  // Everything up to MOV writes its destination register; A..E are NOPs.
  function automatic logic writes_reg(input logic [3:0] op);
    return op <= OP_MOV;
  endfunction

endpackage

// File: rtl/mc_alu.sv
// mc_alu: combinational ALU of the mem_ctrl_p controller.
//   opcode      - instruction opcode (OP_* from mc_pkg)
//   opa1, opa2  - operands, DW bits
//   result      - DW-bit result (0 for opcodes the ALU does not handle)
//   carry       - ADD carry-out, SUB borrow, last bit shifted out, else 0
//   zero        - result == 0
module mc_alu
  import mc_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] opa1,
  input  logic [DW-1:0] opa2,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);

  localparam int SW = $clog2(DW);

  logic [SW-1:0] shamt;
  logic [DW:0]   shl_ext;
  logic [DW:0]   shr_ext;

  // One guard bit on the side the bits leave from: after the shift it holds
  // the last bit pushed out, and stays 0 for a zero shift amount.
  assign shamt   = opa2[SW-1:0];
  assign shl_ext = {1'b0, opa1} << shamt;
  assign shr_ext = {opa1, 1'b0} >> shamt;

  // NOTE: every output of a combinational block gets a default before the
  // case; a path that leaves one unassigned would infer a latch.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: {carry, result} = {1'b0, opa1} + {1'b0, opa2};
      OP_SUB: begin
        result = opa1 - opa2;
        carry  = opa1 < opa2;
      end
      OP_AND: result = opa1 & opa2;
      OP_OR:  result = opa1 | opa2;
      OP_XOR: result = opa1 ^ opa2;
      OP_NOT: result = ~opa1;
      OP_SHL: {carry, result} = shl_ext;
      OP_SHR: {result, carry} = shr_ext;
      OP_MOV: result = opa1;
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mem_ctrl_p.sv
// mem_ctrl_p: multi-cycle program controller. Fetches 16-bit instructions
// from an internal program memory and runs FETCH/DECODE/READ/EXEC/WB, one
// instruction per five cycles, with optional single-step pausing.
//   clk, reset          - rising-edge clock, asynchronous active-low reset
//   S                   - start level, sampled in IDLE and DONE
//   step_mode, step     - pause after each write-back / release one pause
//   prog_we/addr/data   - host program load, honoured in IDLE and DONE only
//   curr, pc, temp      - state, address of instruction in flight, instruction
//   opcode/dest/src1/src2 - fields of temp
//   opa1, opa2, alutemp - latched operands and ALU result
//   carry, zero, d      - flags and program-done
module mem_ctrl_p
  import mc_pkg::*;
#(
  parameter int  DW       = 16,
  parameter int  IM_DEPTH = 16,
  localparam int IAW      = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           S,
  input  logic           step_mode,
  input  logic           step,
  input  logic           prog_we,
  input  logic [IAW-1:0] prog_addr,
  input  logic [15:0]    prog_data,
  output logic [3:0]     curr,
  output logic [IAW-1:0] pc,
  output logic [15:0]    temp,
  output logic [3:0]     opcode,
  output logic [3:0]     dest,
  output logic [3:0]     src1,
  output logic [3:0]     src2,
  output logic [DW-1:0]  opa1,
  output logic [DW-1:0]  opa2,
  output logic [DW-1:0]  alutemp,
  output logic           carry,
  output logic           zero,
  output logic           d
);

  localparam logic [IAW-1:0] PC_LAST = IAW'(IM_DEPTH - 1);

  state_t               state;
  state_t               state_nxt;
  logic [INSTR_W-1:0]   imem [IM_DEPTH];
  logic [DW-1:0]        regs [NUM_REGS];
  logic [DW-1:0]        alu_result;
  logic                 alu_carry;
  logic                 alu_zero;
  logic [DW-1:0]        imm_ext;
  logic                 prog_open;

  assign curr    = state;
  assign d       = (state == ST_DONE);
  assign opcode  = temp[OPC_LSB  +: FIELD_W];
  assign dest    = temp[DST_LSB  +: FIELD_W];
  assign src1    = temp[SRC1_LSB +: FIELD_W];
  assign src2    = temp[SRC2_LSB +: FIELD_W];
  assign imm_ext = DW'(temp[7:0]);

  // The host may only rewrite the program while nothing is executing.
  assign prog_open = (state == ST_IDLE) || (state == ST_DONE);

  mc_alu #(.DW(DW)) u_alu (
    .opcode (opcode),
    .opa1   (opa1),
    .opa2   (opa2),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // NOTE: state-holding blocks use non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (S) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = (opcode == OP_HALT) ? ST_DONE : ST_READ;
      ST_READ:   state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_WB;
      ST_WB: begin
        if (pc == PC_LAST)  state_nxt = ST_DONE;
        else if (step_mode) state_nxt = ST_PAUSE;
        else                state_nxt = ST_FETCH;
      end
      // Dropping step_mode while paused resumes free-running execution.
      ST_PAUSE:  if (step || !step_mode) state_nxt = ST_FETCH;
      ST_DONE:   if (!S) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= '0;
      temp    <= '0;
      opa1    <= '0;
      opa2    <= '0;
      alutemp <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:  if (S) pc <= '0;
        ST_FETCH: temp <= imem[pc];
        ST_READ: begin
          opa1 <= regs[src1];
          opa2 <= regs[src2];
        end
        ST_EXEC: begin
          alutemp <= (opcode == OP_LDI) ? imm_ext : alu_result;
          if (is_flag_op(opcode)) begin
            carry <= alu_carry;
            zero  <= alu_zero;
          end
        end
        // The last slot keeps its address so DONE reports where it stopped.
        ST_WB:    if (pc != PC_LAST) pc <= pc + IAW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == ST_WB && writes_reg(opcode)) begin
      regs[dest] <= alutemp;
    end
  end

  // NOTE: the program memory has no reset; it is plain storage loaded by the
  // host, and leaving it out of reset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (prog_we && prog_open) imem[prog_addr] <= prog_data;
  end

endmodule
